panda_risc_v_flush_ctrl: RTL and testbench

PANDA_RISC_V_FLUSH_CTRL -- requirements
Module: panda_risc_v_flush_ctrl

---
 rtl/panda_risc_v_flush_ctrl_pkg.sv | 30 +++
 rtl/panda_risc_v_flush_ctrl.sv | 121 ++++++++++++
 tb/tb_panda_risc_v_flush_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/panda_risc_v_flush_ctrl_pkg.sv
// Flush controller shared definitions: FSM encodings,
// flush source codes and small helpers.
package panda_risc_v_flush_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_LSU = 3'd1;
  localparam logic [2:0] ST_FLUSH    = 3'd2;
  localparam logic [2:0] ST_INV      = 3'd3;
  localparam logic [2:0] ST_REDIRECT = 3'd4;
  localparam logic [2:0] ST_ACK      = 3'd5;

  localparam logic SRC_CMT    = 1'b0;
  localparam logic SRC_FENCEI = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    WAIT_LSU = ST_WAIT_LSU,
    FLUSH    = ST_FLUSH,
    INV      = ST_INV,
    REDIRECT = ST_REDIRECT,
    ACK      = ST_ACK
  } flush_state_e;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/panda_risc_v_flush_ctrl.sv
// Pipeline flush sequencer: drains the LSU, flushes the pipe,
// optionally invalidates the I-cache, redirects fetch, then acks.
module panda_risc_v_flush_ctrl
  import panda_risc_v_flush_ctrl_pkg::*;
#(
  parameter real    simulation_delay = 1,
  parameter integer DRAIN_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmt_flush_req,
  input  logic [31:0] cmt_flush_addr,
  output logic        cmt_flush_ack,
  input  logic        fencei_req,
  input  logic [31:0] fencei_addr,
  output logic        fencei_ack,
  input  logic        lsu_idle,
  output logic        pipe_flush,
  output logic        icache_inv_req,
  input  logic        icache_inv_done,
  output logic [31:0] m_redirect_addr,
  output logic        m_redirect_valid,
  input  logic        m_redirect_ready,
  output logic        flush_busy,
  output logic        drain_timeout,
  output logic        overlap_err,
  output logic [15:0] flush_cnt
);

  localparam logic [31:0] TMO = 32'(DRAIN_TIMEOUT);

  // simulation_delay only shapes behavioural models; updates here are zero-delay
  if (simulation_delay < 0.0) begin : g_neg_delay
  end

  flush_state_e state;
  flush_state_e state_nxt;
  logic         src;
  logic [31:0]  addr_q;
  logic [31:0]  wait_cnt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmt_flush_req || fencei_req)
          state_nxt = WAIT_LSU;
      end
      WAIT_LSU: begin
        if (lsu_idle)
          state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt = (src == SRC_FENCEI) ? INV : REDIRECT;
      end
      INV: begin
        if (icache_inv_done)
          state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (m_redirect_ready)
          state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      src              <= SRC_CMT;
      addr_q           <= '0;
      wait_cnt         <= '0;
      drain_timeout    <= 1'b0;
      overlap_err      <= 1'b0;
      flush_cnt        <= '0;
      pipe_flush       <= 1'b0;
      icache_inv_req   <= 1'b0;
      m_redirect_valid <= 1'b0;
      cmt_flush_ack    <= 1'b0;
      fencei_ack       <= 1'b0;
    end else begin
      state <= state_nxt;
      // commit wins a tie; a held fencei_req is picked up next IDLE
      if (state == IDLE) begin
        if (cmt_flush_req) begin
          addr_q <= cmt_flush_addr;
          src    <= SRC_CMT;
        end else if (fencei_req) begin
          addr_q <= fencei_addr;
          src    <= SRC_FENCEI;
        end
      end
      if (state == IDLE)
        wait_cnt <= '0;
      else if (state == WAIT_LSU && !lsu_idle && wait_cnt != TMO)
        wait_cnt <= wait_cnt + 32'd1;
      if (state == WAIT_LSU && wait_cnt == TMO)
        drain_timeout <= 1'b1;
      if (cmt_flush_req && state != IDLE)
        overlap_err <= 1'b1;
      // outputs are registered copies of the next-state decode
      pipe_flush       <= (state_nxt == FLUSH);
      icache_inv_req   <= (state_nxt == INV);
      m_redirect_valid <= (state_nxt == REDIRECT);
      cmt_flush_ack    <= (state_nxt == ACK) && (src == SRC_CMT);
      fencei_ack       <= (state_nxt == ACK) && (src == SRC_FENCEI);
      if (state_nxt == ACK)
        flush_cnt <= sat_inc16(flush_cnt);
    end
  end

  assign m_redirect_addr = addr_q;
  assign flush_busy      = (state != IDLE);

endmodule

// File: tb/tb_panda_risc_v_flush_ctrl.sv
// Directed scoreboard bench for the flush controller.
module tb_panda_risc_v_flush_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmt_flush_req;
  logic [31:0] cmt_flush_addr;
  logic        cmt_flush_ack;
  logic        fencei_req;
  logic [31:0] fencei_addr;
  logic        fencei_ack;
  logic        lsu_idle;
  logic        pipe_flush;
  logic        icache_inv_req;
  logic        icache_inv_done;
  logic [31:0] m_redirect_addr;
  logic        m_redirect_valid;
  logic        m_redirect_ready;
  logic        flush_busy;
  logic        drain_timeout;
  logic        overlap_err;
  logic [15:0] flush_cnt;

  typedef struct {
    logic        fencei;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   acks;

  always #5 clk = ~clk;

  panda_risc_v_flush_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .cmt_flush_req    (cmt_flush_req),
    .cmt_flush_addr   (cmt_flush_addr),
    .cmt_flush_ack    (cmt_flush_ack),
    .fencei_req       (fencei_req),
    .fencei_addr      (fencei_addr),
    .fencei_ack       (fencei_ack),
    .lsu_idle         (lsu_idle),
    .pipe_flush       (pipe_flush),
    .icache_inv_req   (icache_inv_req),
    .icache_inv_done  (icache_inv_done),
    .m_redirect_addr  (m_redirect_addr),
    .m_redirect_valid (m_redirect_valid),
    .m_redirect_ready (m_redirect_ready),
    .flush_busy       (flush_busy),
    .drain_timeout    (drain_timeout),
    .overlap_err      (overlap_err),
    .flush_cnt        (flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {13'd0, cmt_flush_ack, fencei_ack, pipe_flush,
            icache_inv_req, m_redirect_valid, flush_busy,
            drain_timeout, overlap_err, flush_cnt[8:0]};
  endfunction

  task automatic push(input logic f, input logic [31:0] a);
    exp_t e;
    e.fencei = f;
    e.addr   = a;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    resetn           = 1'b0;
    cmt_flush_req    = 1'b0;
    cmt_flush_addr   = '0;
    fencei_req       = 1'b0;
    fencei_addr      = '0;
    lsu_idle         = 1'b1;
    icache_inv_done  = 1'b0;
    m_redirect_ready = 1'b1;
    sb.delete();
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // 0: wait icache_inv_req, 1: wait m_redirect_valid
  task automatic wait_sig(input string tag, input int which,
                          input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      hit = (which == 0) ? icache_inv_req : m_redirect_valid;
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic run_until_ack(input string tag, input int budget);
    exp_t e;
    bit   got = 0;
    int   inv_cnt = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (icache_inv_done) begin
        icache_inv_done = 1'b0;
      end else if (icache_inv_req) begin
        inv_cnt++;
        if (inv_cnt == 3) begin
          icache_inv_done = 1'b1;
          inv_cnt = 0;
        end
      end
      if (cmt_flush_ack || fencei_ack) begin
        got = 1;
        chk({tag, "_sb"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({tag, "_kind"}, {30'd0, cmt_flush_ack, fencei_ack},
              e.fencei ? 32'd1 : 32'd2);
          chk({tag, "_addr"}, m_redirect_addr, e.addr);
        end
        if (fencei_ack) fencei_req = 1'b0;
      end
    end
    chk({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic count_acks(input int n);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (cmt_flush_ack || fencei_ack) acks++;
    end
  endtask

  initial begin
    // reset state
    resetn           = 1'b0;
    cmt_flush_req    = 1'b0;
    cmt_flush_addr   = '0;
    fencei_req       = 1'b0;
    fencei_addr      = '0;
    lsu_idle         = 1'b1;
    icache_inv_done  = 1'b0;
    m_redirect_ready = 1'b1;
    step();
    step();
    chk("rst_outs", out_vec(), 32'd0);
    chk("rst_addr", m_redirect_addr, 32'd0);
    chk("rst_cnt", {16'd0, flush_cnt}, 32'd0);
    resetn = 1'b1;
    step();

    // commit flush, exact latency
    cmt_flush_req  = 1'b1;
    cmt_flush_addr = 32'h0000_0100;
    push(1'b0, 32'h0000_0100);
    step();
    cmt_flush_req = 1'b0;
    chk("c1_busy", {31'd0, flush_busy}, 32'd1);
    chk("c1_pf", {31'd0, pipe_flush}, 32'd0);
    step();
    chk("c2_pf", {31'd0, pipe_flush}, 32'd1);
    chk("c2_val", {31'd0, m_redirect_valid}, 32'd0);
    step();
    chk("c3_pf", {31'd0, pipe_flush}, 32'd0);
    chk("c3_val", {31'd0, m_redirect_valid}, 32'd1);
    chk("c3_addr", m_redirect_addr, 32'h0000_0100);
    chk("c3_inv", {31'd0, icache_inv_req}, 32'd0);
    run_until_ack("c4", 1);
    chk("c4_cnt", {16'd0, flush_cnt}, 32'd1);
    step();
    chk("c5_idle", {30'd0, flush_busy, cmt_flush_ack}, 32'd0);

    // fence.i with slow invalidate
    do_reset();
    fencei_req  = 1'b1;
    fencei_addr = 32'h0000_0200;
    push(1'b1, 32'h0000_0200);
    wait_sig("fi_inv_req", 0, 10);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fi_hold_inv", {30'd0, icache_inv_req, m_redirect_valid},
          32'd2);
    end
    step();
    icache_inv_done = 1'b1;
    chk("fi_no_val", {31'd0, m_redirect_valid}, 32'd0);
    step();
    icache_inv_done = 1'b0;
    chk("fi_val", {30'd0, icache_inv_req, m_redirect_valid}, 32'd1);
    chk("fi_addr", m_redirect_addr, 32'h0000_0200);
    run_until_ack("fi", 5);
    count_acks(6);
    chk("fi_once", acks, 32'd0);
    chk("fi_cnt", {16'd0, flush_cnt}, 32'd1);

    // simultaneous commit and fence.i
    do_reset();
    cmt_flush_req  = 1'b1;
    cmt_flush_addr = 32'h10;
    fencei_req     = 1'b1;
    fencei_addr    = 32'h20;
    push(1'b0, 32'h10);
    push(1'b1, 32'h20);
    step();
    cmt_flush_req = 1'b0;
    run_until_ack("both_cmt", 20);
    run_until_ack("both_fi", 30);
    chk("both_cnt", {16'd0, flush_cnt}, 32'd2);
    count_acks(5);
    chk("both_extra", acks, 32'd0);

    // LSU never drains for 300 cycles
    do_reset();
    lsu_idle       = 1'b0;
    cmt_flush_req  = 1'b1;
    cmt_flush_addr = 32'h0000_0300;
    push(1'b0, 32'h0000_0300);
    step();
    cmt_flush_req = 1'b0;
    for (int i = 1; i < 256; i++) step();
    chk("to_before", {30'd0, drain_timeout, pipe_flush}, 32'd0);
    step();
    chk("to_set", {31'd0, drain_timeout}, 32'd1);
    chk("to_busy", {31'd0, flush_busy}, 32'd1);
    for (int i = 257; i < 300; i++) step();
    chk("to_no_pf", {31'd0, pipe_flush}, 32'd0);
    lsu_idle = 1'b1;
    run_until_ack("to", 10);
    chk("to_sticky", {31'd0, drain_timeout}, 32'd1);
    chk("to_cnt", {16'd0, flush_cnt}, 32'd1);

    // redirect back-pressure and overlapping commit
    do_reset();
    m_redirect_ready = 1'b0;
    cmt_flush_req    = 1'b1;
    cmt_flush_addr   = 32'h0000_0400;
    push(1'b0, 32'h0000_0400);
    step();
    cmt_flush_req = 1'b0;
    wait_sig("bp_val", 1, 10);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_val", {31'd0, m_redirect_valid}, 32'd1);
      chk("bp_hold_addr", m_redirect_addr, 32'h0000_0400);
      if (i == 1) begin
        cmt_flush_req  = 1'b1;
        cmt_flush_addr = 32'h0000_0500;
      end else begin
        cmt_flush_req = 1'b0;
      end
      step();
    end
    m_redirect_ready = 1'b1;
    chk("bp_ovl", {31'd0, overlap_err}, 32'd1);
    run_until_ack("bp", 3);
    count_acks(8);
    chk("bp_extra", acks, 32'd0);
    chk("bp_idle", {31'd0, flush_busy}, 32'd0);
    chk("bp_cnt", {16'd0, flush_cnt}, 32'd1);

    // reset during invalidate
    do_reset();
    fencei_req  = 1'b1;
    fencei_addr = 32'h0000_0600;
    wait_sig("rs_inv", 0, 10);
    resetn = 1'b0;
    #1;
    chk("rs_outs", out_vec(), 32'd0);
    chk("rs_addr", m_redirect_addr, 32'd0);
    fencei_req = 1'b0;
    step();
    resetn = 1'b1;
    count_acks(8);
    chk("rs_no_ack", acks, 32'd0);
    chk("rs_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("rs_idle", {31'd0, flush_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
